// File: rtl/avalon_ram_wait_model.sv
// Avalon-MM slave RAM with configurable base/depth, wait-state modes (none, fixed, LFSR),
// byte-lane writes, sticky error detection and saturating read/write transaction counters.
module avalon_ram_wait_model #(
   parameter int unsigned                DATA_WIDTH  = 32,
   parameter int unsigned                ADDR_WIDTH  = 32,
   parameter int unsigned                DEPTH_WORDS = 16384,
   parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = 32'hBFC00000,
   parameter int unsigned                WAIT_MODE   = 1,
   parameter int unsigned                WAIT_CYCLES = 1,
   parameter int unsigned                MAX_WAIT    = 3,
   parameter logic [15:0]                LFSR_SEED   = 16'hACE1,
   parameter string                      INIT_FILE   = "",
   parameter logic [DATA_WIDTH-1:0]      ERR_DATA    = 32'hDEADBEEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic [DATA_WIDTH-1:0]   writedata,
   output logic                    waitrequest,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    err,
   output logic [15:0]             rd_count,
   output logic [15:0]             wr_count
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(NB);
   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NB - 1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rd_q, rd_d, wr_q, wr_d;
   logic [NB-1:0]           be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [15:0]             wcnt_q, wcnt_d;
   logic [15:0]             lfsr_q, lfsr_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic [15:0]             rd_count_q, rd_count_d;
   logic [15:0]             wr_count_q, wr_count_d;

   logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0]   cur_addr, offset, idx;
   logic                    cur_rd, cur_wr, access_ok, enter_ack, mem_we;
   logic [IDX_W-1:0]        mem_idx;
   logic [15:0]             wait_sel;
   logic                    lfsr_fb;

   initial begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
   end

   // In IDLE the request is still on the bus; afterwards only the latched copy counts.
   always_comb begin
      cur_addr = addr_q;
      cur_rd   = rd_q;
      cur_wr   = wr_q;
      if (state_q == StIdle) begin
         cur_addr = address;
         cur_rd   = read;
         cur_wr   = write;
      end
      offset    = cur_addr - BASE_ADDR;
      idx       = offset >> OFF_W;
      mem_idx   = idx[IDX_W-1:0];
      access_ok = (cur_addr >= BASE_ADDR) && (idx < DEPTH_A) &&
                  ((cur_addr & ALIGN_MASK) == '0) && !(cur_rd && cur_wr);
   end

   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   always_comb begin
      wait_sel = '0;
      if (WAIT_MODE == 1) begin
         wait_sel = 16'(WAIT_CYCLES);
      end else if (WAIT_MODE == 2) begin
         wait_sel = lfsr_q % 16'(MAX_WAIT + 1);
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      wcnt_d     = wcnt_q;
      lfsr_d     = lfsr_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      enter_ack  = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         StIdle: begin
            if (read || write) begin
               addr_d  = address;
               rd_d    = read;
               wr_d    = write;
               be_d    = byteenable;
               wdata_d = writedata;
               wcnt_d  = wait_sel;
               lfsr_d  = {lfsr_q[14:0], lfsr_fb};
               if (wait_sel == '0) begin
                  state_d   = StAck;
                  enter_ack = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            // Master must hold the request while stalled; completion still uses latched values.
            if ((address != addr_q) || (read != rd_q) || (write != wr_q)) err_d = 1'b1;
            if (wcnt_q <= 16'd1) begin
               wcnt_d    = '0;
               state_d   = StAck;
               enter_ack = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 16'd1;
            end
         end
         StAck: begin
            state_d = StIdle;
            if (access_ok) begin
               mem_we = wr_q;
               if (rd_q && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
               if (wr_q && wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (enter_ack) begin
         if (!access_ok) begin
            err_d = 1'b1;
            if (cur_rd) rdata_d = ERR_DATA;
         end else if (cur_rd) begin
            rdata_d = mem[mem_idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         wcnt_q     <= '0;
         lfsr_q     <= LFSR_SEED;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         wcnt_q     <= wcnt_d;
         lfsr_q     <= lfsr_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Memory is not reset; an async reset leaves StAck immediately, so no commit can follow.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NB; b++) begin
            if (be_q[b]) mem[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
         end
      end
   end

   assign waitrequest = reset && (read || write) && (state_q != StAck);
   assign readdata    = rdata_q;
   assign err         = err_q;
   assign rd_count    = rd_count_q;
   assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_avalon_ram_wait_model.sv
// Randomized bench for avalon_ram_wait_model: a fixed-wait and an LFSR-wait instance
// checked against a word-level memory/counter model derived from the bus rules.
module tb_avalon_ram_wait_model;

   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int unsigned DEPTH = 16384;
   localparam logic [31:0] ERRD  = 32'hDEADBEEF;
   localparam int          FIXW  = 2;
   localparam int          MAXW  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sel = 1'b0;
   logic [31:0] address = '0;
   logic        read = 1'b0, write = 1'b0;
   logic [3:0]  byteenable = '0;
   logic [31:0] writedata = '0;

   logic        f_wreq, r_wreq, f_err, r_err;
   logic [31:0] f_rdata, r_rdata;
   logic [15:0] f_rdc, r_rdc, f_wrc, r_wrc;
   logic        waitrequest, err;
   logic [31:0] readdata;
   logic [15:0] rd_count, wr_count;

   assign waitrequest = sel ? r_wreq : f_wreq;
   assign readdata    = sel ? r_rdata : f_rdata;
   assign err         = sel ? r_err : f_err;
   assign rd_count    = sel ? r_rdc : f_rdc;
   assign wr_count    = sel ? r_wrc : f_wrc;

   avalon_ram_wait_model #(.WAIT_MODE(1), .WAIT_CYCLES(FIXW)) u_fix (
      .clk(clk), .reset(rst_n), .address(address), .read(read & ~sel), .write(write & ~sel),
      .byteenable(byteenable), .writedata(writedata), .waitrequest(f_wreq), .readdata(f_rdata),
      .err(f_err), .rd_count(f_rdc), .wr_count(f_wrc));

   avalon_ram_wait_model #(.WAIT_MODE(2), .MAX_WAIT(MAXW)) u_rnd (
      .clk(clk), .reset(rst_n), .address(address), .read(read & sel), .write(write & sel),
      .byteenable(byteenable), .writedata(writedata), .waitrequest(r_wreq), .readdata(r_rdata),
      .err(r_err), .rd_count(r_rdc), .wr_count(r_wrc));

   always #5 clk = ~clk;

   // Reference model: sparse word memories, counters, sticky error, last read data.
   logic [31:0] mem_f [int unsigned];
   logic [31:0] mem_r [int unsigned];
   logic [15:0] exp_rd [2];
   logic [15:0] exp_wr [2];
   logic        exp_err [2];
   logic [31:0] exp_rdata [2];
   int          n_cmp = 0;
   int          n_fail = 0;

   function automatic logic [31:0] mget(input logic s, input int unsigned i);
      if (s) return mem_r.exists(i) ? mem_r[i] : 32'h0;
      return mem_f.exists(i) ? mem_f[i] : 32'h0;
   endfunction

   function automatic bit addr_ok(input logic [31:0] a);
      return (a >= BASE) && (((a - BASE) >> 2) < DEPTH) && (a[1:0] == 2'b00);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         exp_rd[s] = '0; exp_wr[s] = '0; exp_err[s] = 1'b0; exp_rdata[s] = '0;
      end
   endtask

   // One transaction; returns stall-cycle count, observed and expected readdata.
   task automatic xfer(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input bit perturb, output int waits,
                       output logic [31:0] got, output logic [31:0] ev);
      bit          done;
      bit          ok;
      int unsigned wi;
      logic [31:0] mask;
      address = a; read = rd; write = wr; byteenable = be; writedata = d;
      waits = 1;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(posedge clk); #1;
         if (!waitrequest) done = 1'b1;
         else begin
            waits++;
            if (perturb && c == 0) address = a ^ 32'h4;
         end
      end
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL xfer_timeout: waitrequest=%b after %0d cycles, required 0", waitrequest,
                  waits);
      end
      got = readdata;
      ok = addr_ok(a) && !(rd && wr);
      wi = (a - BASE) >> 2;
      if (!ok) begin
         exp_err[sel] = 1'b1;
         if (rd) exp_rdata[sel] = ERRD;
      end else if (rd) begin
         exp_rdata[sel] = mget(sel, wi);
         if (exp_rd[sel] != 16'hFFFF) exp_rd[sel]++;
      end else begin
         mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         if (sel) mem_r[wi] = (mget(sel, wi) & ~mask) | (d & mask);
         else mem_f[wi] = (mget(sel, wi) & ~mask) | (d & mask);
         if (exp_wr[sel] != 16'hFFFF) exp_wr[sel]++;
      end
      if (perturb) exp_err[sel] = 1'b1;
      ev = exp_rdata[sel];
      @(posedge clk); #1;
   endtask

   task automatic bus_idle();
      read = 1'b0; write = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; sel = 1'b0;
      #1;
      n_cmp++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_wreq: got %b, required 0", waitrequest); end
      n_cmp++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", readdata); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err); end
      n_cmp++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL rst_rdc: got %h, required 0", rd_count); end
      n_cmp++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL rst_wrc: got %h, required 0", wr_count); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_wait();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      xfer(0, 1, BASE, 4'hF, 32'h24020005, 0, w, g, e);
      n_cmp++; if (w !== FIXW + 1) begin n_fail++; $display("FAIL fix_wr_wait: got %0d, required %0d", w, FIXW + 1); end
      xfer(1, 0, BASE, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (w !== FIXW + 1) begin n_fail++; $display("FAIL fix_rd_wait: got %0d, required %0d", w, FIXW + 1); end
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL fix_rd_data: got %h, required %h", g, e); end
      n_cmp++; if (rd_count !== exp_rd[0]) begin n_fail++; $display("FAIL fix_rdc: got %h, required %h", rd_count, exp_rd[0]); end
      n_cmp++; if (wr_count !== exp_wr[0]) begin n_fail++; $display("FAIL fix_wrc: got %h, required %h", wr_count, exp_wr[0]); end
      bus_idle();
      n_cmp++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL idle_wreq: got %b, required 0", waitrequest); end
   endtask

   task automatic test_byte_lanes();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      xfer(0, 1, BASE + 4, 4'hF, 32'hAABBCCDD, 0, w, g, e);
      xfer(0, 1, BASE + 4, 4'b0101, 32'h11223344, 0, w, g, e);
      xfer(1, 0, BASE + 4, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL lanes_0101: got %h, required %h", g, e); end
      xfer(0, 1, BASE + 4, 4'h0, 32'h55555555, 0, w, g, e);
      xfer(1, 0, BASE + 4, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL lanes_none: got %h, required %h", g, e); end
      n_cmp++; if (wr_count !== exp_wr[0]) begin n_fail++; $display("FAIL lanes_wrc: got %h, required %h", wr_count, exp_wr[0]); end
      bus_idle();
   endtask

   task automatic test_errors();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      xfer(1, 0, BASE + 32'h10000, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL oor_data: got %h, required %h", g, e); end
      n_cmp++; if (w !== FIXW + 1) begin n_fail++; $display("FAIL oor_wait: got %0d, required %0d", w, FIXW + 1); end
      n_cmp++; if (err !== exp_err[0]) begin n_fail++; $display("FAIL oor_err: got %b, required %b", err, exp_err[0]); end
      n_cmp++; if (rd_count !== exp_rd[0]) begin n_fail++; $display("FAIL oor_rdc: got %h, required %h", rd_count, exp_rd[0]); end
      xfer(0, 1, BASE + 2, 4'hF, 32'h0BADF00D, 0, w, g, e);
      xfer(1, 0, BASE, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL misalign_mem: got %h, required %h", g, e); end
      xfer(1, 1, BASE, 4'hF, 32'h12345678, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL both_data: got %h, required %h", g, e); end
      xfer(1, 0, BASE - 4, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL below_data: got %h, required %h", g, e); end
      n_cmp++; if (err !== exp_err[0]) begin n_fail++; $display("FAIL err_sticky: got %b, required %b", err, exp_err[0]); end
      n_cmp++; if (wr_count !== exp_wr[0]) begin n_fail++; $display("FAIL err_wrc: got %h, required %h", wr_count, exp_wr[0]); end
      bus_idle();
   endtask

   task automatic test_random();
      int w; int r; bit rd; bit wr; logic [31:0] a, g, e;
      sel = 1'b0;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 15);
         a = BASE + ($urandom_range(0, 7) << 2);
         if (r == 0) a = a + $urandom_range(1, 3);
         else if (r == 1) a = BASE + DEPTH * 4 + ($urandom_range(0, 3) << 2);
         else if (r == 2) a = BASE - 4;
         rd = 1'($urandom_range(0, 1));
         wr = !rd;
         if (r == 3) begin rd = 1'b1; wr = 1'b1; end
         xfer(rd, wr, a, 4'($urandom), $urandom, 0, w, g, e);
         n_cmp++; if (w !== FIXW + 1) begin n_fail++; $display("FAIL rnd_wait[%0d]: got %0d, required %0d", i, w, FIXW + 1); end
         if (rd) begin
            n_cmp++; if (g !== e) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h, required %h", i, g, e); end
         end
         if ($urandom_range(0, 3) == 0) bus_idle();
      end
      n_cmp++; if (err !== exp_err[0]) begin n_fail++; $display("FAIL rnd_err: got %b, required %b", err, exp_err[0]); end
      n_cmp++; if (rd_count !== exp_rd[0]) begin n_fail++; $display("FAIL rnd_rdc: got %h, required %h", rd_count, exp_rd[0]); end
      n_cmp++; if (wr_count !== exp_wr[0]) begin n_fail++; $display("FAIL rnd_wrc: got %h, required %h", wr_count, exp_wr[0]); end
      bus_idle();
   endtask

   task automatic test_reset_abort();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      xfer(0, 1, BASE + 8, 4'hF, 32'h55667788, 0, w, g, e);
      bus_idle();
      address = BASE + 8; write = 1'b1; byteenable = 4'hF; writedata = 32'h99999999;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL abort_wreq: got %b, required 0", waitrequest); end
      n_cmp++; if (rd_count !== 16'h0) begin n_fail++; $display("FAIL abort_rdc: got %h, required 0", rd_count); end
      n_cmp++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL abort_wrc: got %h, required 0", wr_count); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b, required 0", err); end
      write = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      xfer(1, 0, BASE + 8, 4'h0, 32'h0, 0, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL abort_mem: got %h, required %h", g, e); end
      n_cmp++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL abort_wrc_after: got %h, required 0", wr_count); end
      bus_idle();
   endtask

   task automatic test_lfsr_waits();
      int w; int hist [MAXW+1]; logic [31:0] a, g, e;
      for (int k = 0; k <= MAXW; k++) hist[k] = 0;
      sel = 1'b1;
      for (int i = 0; i < 8; i++) begin
         xfer(0, 1, BASE + (i << 2), 4'hF, $urandom, 0, w, g, e);
      end
      for (int i = 0; i < 200; i++) begin
         a = BASE + ($urandom_range(0, 15) << 2);
         xfer(1, 0, a, 4'h0, 32'h0, 0, w, g, e);
         n_cmp++;
         if (w < 1 || w > MAXW + 1) begin
            n_fail++; $display("FAIL lfsr_wait[%0d]: got %0d extra, required 0..%0d", i, w - 1, MAXW);
         end else hist[w-1]++;
         n_cmp++; if (g !== e) begin n_fail++; $display("FAIL lfsr_data[%0d]: got %h, required %h", i, g, e); end
      end
      for (int k = 0; k <= MAXW; k++) begin
         n_cmp++; if (hist[k] == 0) begin n_fail++; $display("FAIL lfsr_cover: wait %0d seen 0 times, required >0", k); end
      end
      n_cmp++; if (rd_count !== 16'd200) begin n_fail++; $display("FAIL lfsr_rdc: got %0d, required 200", rd_count); end
      bus_idle();
      sel = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      force u_fix.rd_count_q = 16'hFFFE;
      @(posedge clk); #1;
      release u_fix.rd_count_q;
      exp_rd[0] = 16'hFFFE;
      for (int i = 0; i < 3; i++) begin
         xfer(1, 0, BASE + 4, 4'h0, 32'h0, 0, w, g, e);
         n_cmp++; if (rd_count !== exp_rd[0]) begin n_fail++; $display("FAIL sat_rdc[%0d]: got %h, required %h", i, rd_count, exp_rd[0]); end
      end
      bus_idle();
   endtask

   task automatic test_protocol();
      int w; logic [31:0] g, e;
      sel = 1'b0;
      n_cmp++; if (err !== exp_err[0]) begin n_fail++; $display("FAIL proto_pre_err: got %b, required %b", err, exp_err[0]); end
      xfer(1, 0, BASE + 8, 4'h0, 32'h0, 1, w, g, e);
      n_cmp++; if (g !== e) begin n_fail++; $display("FAIL proto_data: got %h, required %h", g, e); end
      n_cmp++; if (err !== exp_err[0]) begin n_fail++; $display("FAIL proto_err: got %b, required %b", err, exp_err[0]); end
      bus_idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fixed_wait();
      test_byte_lanes();
      test_errors();
      test_random();
      test_reset_abort();
      test_lfsr_waits();
      test_saturation();
      test_protocol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
